// File: rtl/speed_cmd_arbiter.sv
// Turns keyboard strobes and raw buttons into spaced one-cycle speed_up/down/rst pulses,
// with debounce, auto-repeat, one-deep pending slot and a shadow copy of the divider.
module speed_cmd_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_DELAY      = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int MIN_GAP         = 4,
    parameter int DIV_DEFAULT     = 1227,
    parameter int DIV_STEP        = 4,
    parameter int DIV_MIN         = 227,
    parameter int DIV_MAX         = 4227
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        kbd_up_i,
    input  logic        kbd_down_i,
    input  logic        kbd_rst_i,
    input  logic        btn_up_i,
    input  logic        btn_down_i,
    input  logic        btn_rst_i,
    output logic        speed_up_o,
    output logic        speed_down_o,
    output logic        speed_rst_o,
    output logic        busy_o,
    output logic        at_limit_o,
    output logic [31:0] shadow_div_o
);

    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX    = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int GW      = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int BTN_RST = 2;

    typedef enum logic [1:0] {B_IDLE, B_FIRE, B_HOLD, B_REPEAT} btn_state_e;
    typedef enum logic [1:0] {CMD_UP, CMD_DOWN, CMD_RST} cmd_e;

    // Button index 0 = up, 1 = down, 2 = rst.
    logic [2:0]     btn_raw;
    logic [2:0]     sync1_q, sync2_q, deb_q;
    logic [DBW-1:0] dcnt_q [3];
    btn_state_e     bst_q  [3];
    logic [TW-1:0]  tmr_q  [3];
    logic [2:0]     breq_q;

    logic        resync_q, resync_d;
    logic        pend_vld_q, pend_vld_d;
    cmd_e        pend_cmd_q, pend_cmd_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0] shadow_q, shadow_d;
    logic        up_q, up_d, down_q, down_d, rst_q, rst_d, lim_q, lim_d;

    logic win_vld, lim_hit, req_vld, eff_vld, issue;
    cmd_e win_cmd, eff_cmd;

    assign btn_raw = {btn_rst_i, btn_down_i, btn_up_i};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]  <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // Leaving HOLD preloads the timer with 1 so that repeat pulses land exactly
    // HOLD_DELAY + k*REPEAT_PERIOD cycles after the first pulse despite the request register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            breq_q <= '0;
            for (int i = 0; i < 3; i++) begin
                bst_q[i] <= B_IDLE;
                tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                breq_q[i] <= 1'b0;
                if (!deb_q[i]) begin
                    bst_q[i] <= B_IDLE;
                    tmr_q[i] <= '0;
                end else begin
                    case (bst_q[i])
                        B_IDLE: begin
                            bst_q[i]  <= B_FIRE;
                            breq_q[i] <= 1'b1;
                        end
                        B_FIRE: begin
                            bst_q[i] <= B_HOLD;
                            tmr_q[i] <= '0;
                        end
                        B_HOLD: begin
                            if (tmr_q[i] != TW'(HOLD_DELAY - 1)) begin
                                tmr_q[i] <= tmr_q[i] + TW'(1);
                            end else if (i != BTN_RST) begin
                                bst_q[i] <= B_REPEAT;
                                tmr_q[i] <= TW'(1);
                            end
                        end
                        B_REPEAT: begin
                            if (tmr_q[i] == TW'(REPEAT_PERIOD - 1)) begin
                                breq_q[i] <= 1'b1;
                                tmr_q[i]  <= '0;
                            end else begin
                                tmr_q[i] <= tmr_q[i] + TW'(1);
                            end
                        end
                        default: bst_q[i] <= B_IDLE;
                    endcase
                end
            end
        end
    end

    // Winner selection: rst from any source, then keyboard, then buttons.
    always_comb begin
        win_vld = 1'b0;
        win_cmd = CMD_UP;
        if (kbd_rst_i || breq_q[BTN_RST]) begin
            win_vld = 1'b1;
            win_cmd = CMD_RST;
        end else if (kbd_up_i ^ kbd_down_i) begin
            win_vld = 1'b1;
            win_cmd = kbd_up_i ? CMD_UP : CMD_DOWN;
        end else if (breq_q[0] ^ breq_q[1]) begin
            win_vld = 1'b1;
            win_cmd = breq_q[0] ? CMD_UP : CMD_DOWN;
        end
        lim_hit = win_vld &&
                  ((win_cmd == CMD_UP   && shadow_q < 32'(DIV_MIN + DIV_STEP)) ||
                   (win_cmd == CMD_DOWN && shadow_q > 32'(DIV_MAX - DIV_STEP)));
        req_vld = win_vld && !lim_hit;
    end

    // A pending rst (or the post-reset resync) blocks newcomers; pending up/down yields to them.
    always_comb begin
        eff_vld = 1'b0;
        eff_cmd = pend_cmd_q;
        if (resync_q) begin
            eff_vld = 1'b1;
            eff_cmd = CMD_RST;
        end else if (pend_vld_q && pend_cmd_q == CMD_RST) begin
            eff_vld = 1'b1;
        end else if (req_vld) begin
            eff_vld = 1'b1;
            eff_cmd = win_cmd;
        end else if (pend_vld_q) begin
            eff_vld = 1'b1;
        end
        issue = eff_vld && (gap_q == '0);

        resync_d   = 1'b0;
        pend_vld_d = eff_vld && !issue;
        pend_cmd_d = eff_cmd;
        lim_d      = lim_hit;
        up_d       = issue && eff_cmd == CMD_UP;
        down_d     = issue && eff_cmd == CMD_DOWN;
        rst_d      = issue && eff_cmd == CMD_RST;

        if (issue)             gap_d = GW'(MIN_GAP);
        else if (gap_q != '0)  gap_d = gap_q - GW'(1);
        else                   gap_d = '0;

        shadow_d = shadow_q;
        if (up_d)   shadow_d = shadow_q - 32'(DIV_STEP);
        if (down_d) shadow_d = shadow_q + 32'(DIV_STEP);
        if (rst_d)  shadow_d = 32'(DIV_DEFAULT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            resync_q   <= 1'b1;
            pend_vld_q <= 1'b0;
            pend_cmd_q <= CMD_UP;
            gap_q      <= '0;
            shadow_q   <= 32'(DIV_DEFAULT);
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            rst_q      <= 1'b0;
            lim_q      <= 1'b0;
        end else begin
            resync_q   <= resync_d;
            pend_vld_q <= pend_vld_d;
            pend_cmd_q <= pend_cmd_d;
            gap_q      <= gap_d;
            shadow_q   <= shadow_d;
            up_q       <= up_d;
            down_q     <= down_d;
            rst_q      <= rst_d;
            lim_q      <= lim_d;
        end
    end

    assign speed_up_o   = up_q;
    assign speed_down_o = down_q;
    assign speed_rst_o  = rst_q;
    assign at_limit_o   = lim_q;
    assign busy_o       = (gap_q != '0) || pend_vld_q;
    assign shadow_div_o = shadow_q;

endmodule
